// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the planned matching receiver.
// Holds state encodings, parity modes and the parity-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // data_xor is the even-parity bit; odd parity is its inverse
    function automatic logic par_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: down-counter reloaded on clear or terminal count.
// o_bit_end marks the last cycle of each bit period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_bit_end = !i_clear && (r_cnt == '0);

endmodule

// File: rtl/uart_tx_frm.sv
// Parametrised UART transmitter with valid/ready input and a one-entry holding
// register so consecutive frames leave the line with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a word
// START | start bit (low) on the line
// DATA  | data bits, LSB first
// PAR   | parity bit
// STOP  | stop bit(s), high
module uart_tx_frm
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    localparam int BW = $clog2(DATA_BITS + 1);

    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN || (STOP_BITS != 1 && STOP_BITS != 2))
    begin : g_bad_param
        $error("uart_tx_frm: illegal parameter value");
    end

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_x;
    logic                 r_tx;
    logic                 r_done;

    logic w_fire;
    logic w_clear;
    logic w_bit_end;
    logic w_frame_end;

    assign w_fire      = i_valid && !r_hold_full;
    assign w_clear     = (r_state == IDLE);
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_stop_idx == 1'(STOP_BITS - 1));

    uart_baud_cnt #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_par_x     <= 1'b0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // At the frame-end edge an accepted word bypasses the hold register
            if (w_fire && r_state != IDLE && !w_frame_end) begin
                r_hold      <= i_data;
                r_hold_full <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_fire) begin
                        r_shift <= i_data;
                        r_par_x <= ^i_data;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_state <= PAR;
                                r_tx    <= par_bit(r_par_x, PARITY);
                            end else begin
                                r_state    <= STOP;
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                PAR: begin
                    if (w_bit_end) begin
                        r_state    <= STOP;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_frame_end) begin
                            r_done <= 1'b1;
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_par_x     <= ^r_hold;
                                r_hold_full <= 1'b0;
                                r_tx        <= 1'b0;
                                r_state     <= START;
                            end else if (w_fire) begin
                                r_shift <= i_data;
                                r_par_x <= ^i_data;
                                r_tx    <= 1'b0;
                                r_state <= START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = !r_hold_full;
    assign o_tx    = r_tx;
    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_uart_tx_frm.sv
// Self-checking bench: three transmitter configurations (8N1, 7E2, 8O1) checked
// cycle by cycle against a frame-level reference model.
module tb_uart_tx_frm;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       va, vb, vc;
    logic [7:0] da;
    logic [6:0] db;
    logic [7:0] dc;
    logic       ra, rb, rc, txa, txb, txc, ba, bb, bc, dna, dnb, dnc;
    logic [2:0] sa, sb, sc;

    uart_tx_frm #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_valid(va), .i_data(da), .o_ready(ra),
        .o_tx(txa), .o_busy(ba), .o_done(dna), .o_state(sa));
    uart_tx_frm #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_valid(vb), .i_data(db), .o_ready(rb),
        .o_tx(txb), .o_busy(bb), .o_done(dnb), .o_state(sb));
    uart_tx_frm #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .i_valid(vc), .i_data(dc), .o_ready(rc),
        .o_tx(txc), .o_busy(bc), .o_done(dnc), .o_state(sc));

    int sel = 0;
    logic       tx_s, busy_s, done_s, ready_s;
    logic [2:0] st_s;

    always_comb begin
        tx_s = txa; busy_s = ba; done_s = dna; ready_s = ra; st_s = sa;
        case (sel)
            1: begin tx_s = txb; busy_s = bb; done_s = dnb; ready_s = rb; st_s = sb; end
            2: begin tx_s = txc; busy_s = bc; done_s = dnc; ready_s = rc; st_s = sc; end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cfg_dbits(int s);
        return (s == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_par(int s);
        return (s == 1) ? 2 : ((s == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_stops(int s);
        return (s == 1) ? 2 : 1;
    endfunction
    function automatic int flen(int s);
        return CPB * (1 + cfg_dbits(s) + ((cfg_par(s) != 0) ? 1 : 0) + cfg_stops(s));
    endfunction

    // Line level of bit position idx within a frame carrying data
    function automatic logic frame_bit(int s, int data, int idx);
        int nb = cfg_dbits(s);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += (data >> i) & 1;
        if (idx == 0) return 1'b0;
        if (idx <= nb) return logic'((data >> (idx - 1)) & 1);
        if (cfg_par(s) != 0 && idx == nb + 1)
            return (cfg_par(s) == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return 1'b1;
    endfunction

    function automatic int exp_state(int s, int idx);
        int nb = cfg_dbits(s);
        if (idx == 0) return 1;
        if (idx <= nb) return 2;
        if (cfg_par(s) != 0 && idx == nb + 1) return 3;
        return 4;
    endfunction

    task automatic set_in(input int s, input logic v, input int d);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        case (s)
            0: begin va = v; da = d[7:0]; end
            1: begin vb = v; db = d[6:0]; end
            default: begin vc = v; dc = d[7:0]; end
        endcase
    endtask

    // mode 0: single frame; 1: second word offered the next cycle (goes to hold),
    // then a third word offered while hold is full; 2: second word offered in
    // the last stop cycle (direct load, no hold)
    task automatic run_seq(input int s, input int d0, input int d1, input int mode, input string tag);
        int L = flen(s);
        int total = ((mode == 0) ? 1 : 2) * L;
        int fr, idx, dd;
        logic e_tx, e_busy, e_done, e_ready;
        int e_st;
        sel = s;
        @(negedge clk);
        set_in(s, 1'b1, d0);
        @(posedge clk); #1;
        for (int c = 0; c < total + 4; c++) begin
            case (mode)
                1: begin
                    if (c == 0) set_in(s, 1'b1, d1);
                    else if (c < L - 4) set_in(s, 1'b1, int'($urandom));
                    else set_in(s, 1'b0, int'($urandom));
                end
                2: begin
                    if (c == L - 1) set_in(s, 1'b1, d1);
                    else set_in(s, 1'b0, int'($urandom));
                end
                default: set_in(s, 1'b0, int'($urandom));
            endcase
            @(negedge clk);
            if (c < total) begin
                fr = c / L;
                dd = (fr == 0) ? d0 : d1;
                idx = (c % L) / CPB;
                e_tx = frame_bit(s, dd, idx);
                e_busy = 1'b1;
                e_done = (c > 0 && (c % L) == 0);
                e_st = exp_state(s, idx);
            end else begin
                e_tx = 1'b1;
                e_busy = 1'b0;
                e_done = (c == total);
                e_st = 0;
            end
            e_ready = (mode == 1 && c >= 1 && c < L) ? 1'b0 : 1'b1;
            check($sformatf("%s tx c%0d", tag, c), 32'(tx_s), 32'(e_tx));
            check($sformatf("%s busy c%0d", tag, c), 32'(busy_s), 32'(e_busy));
            check($sformatf("%s done c%0d", tag, c), 32'(done_s), 32'(e_done));
            check($sformatf("%s ready c%0d", tag, c), 32'(ready_s), 32'(e_ready));
            check($sformatf("%s state c%0d", tag, c), 32'(st_s), 32'(e_st));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        set_in(0, 1'b0, 0);
        db = '0; dc = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset tx", 32'(txa), 32'd1);
        check("reset ready", 32'(ra), 32'd1);
        check("reset busy", 32'(ba), 32'd0);
        check("reset done", 32'(dna), 32'd0);
        check("reset state", 32'(sa), 32'd0);
        check("reset tx 7E2", 32'(txb), 32'd1);
        check("reset tx 8O1", 32'(txc), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(0, 'hA5, 0, 0, "8N1 A5");
        run_seq(1, 'h13, 0, 0, "7E2 13");
        run_seq(2, 'h00, 0, 0, "8O1 00");
        run_seq(2, 'hFF, 0, 0, "8O1 FF");
        run_seq(0, 'h55, 'h0F, 1, "b2b 55/0F");
        run_seq(1, 'h2A, 'h51, 2, "7E2 late");
        run_seq(2, 'h81, 'h7E, 1, "8O1 b2b");

        for (int i = 0; i < 8; i++) begin
            run_seq(int'($urandom_range(0, 2)), int'($urandom), int'($urandom),
                    int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        // Reset in the middle of DATA with the hold register full
        sel = 0;
        @(negedge clk);
        set_in(0, 1'b1, 'h5A);
        @(posedge clk); #1;
        set_in(0, 1'b1, 'hC3);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0);
        repeat (14) @(posedge clk);
        #1;
        check("mid pre tx", 32'(txa), 32'(frame_bit(0, 'h5A, 15 / CPB)));
        check("mid pre ready", 32'(ra), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid rst tx", 32'(txa), 32'd1);
        check("mid rst busy", 32'(ba), 32'd0);
        check("mid rst ready", 32'(ra), 32'd1);
        check("mid rst state", 32'(sa), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check($sformatf("post rst tx c%0d", c), 32'(txa), 32'd1);
            check($sformatf("post rst done c%0d", c), 32'(dna), 32'd0);
            check($sformatf("post rst ready c%0d", c), 32'(ra), 32'd1);
            check($sformatf("post rst busy c%0d", c), 32'(ba), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frm.md
# uart_tx_frm

Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. Adds configurable data width, parity and stop bits, plus a valid/ready input handshake with a one-entry holding register so frames go back-to-back with no idle gap. It sits between a byte producer (command/debug logic) and the serial TX pin.

## Interface
- CLK_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: parity mode; 0 none, 1 odd, 2 even.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  producer has a word on i_data.
- i_data  in  DATA_BITS  word to transmit, sent LSB first.
- o_ready  out  1  block accepts a word this cycle; transfer when i_valid && o_ready.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  a frame is on the line (any state except IDLE).
- o_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- o_state  out  3  current FSM state, for debug.

## Operation
- Reset values: o_tx=1, o_busy=0, o_done=0, o_ready=1, o_state=IDLE; shift register, holding register, bit and clock counters cleared; holding register empty.
- Reset asserted mid-frame: o_tx goes high immediately. The frame in progress and any held word are discarded. No o_done pulse.
- FSM states and transitions:
  - IDLE: o_tx=1. On an accepted transfer, go to START.
  - START: o_tx=0. After one bit period, go to DATA.
  - DATA: send DATA_BITS bits, LSB first. Then go to PAR if PARITY!=0, otherwise go to STOP.
  - PAR: send the parity bit. Even parity bit = XOR of the data bits. Odd parity bit = its inverse. Then go to STOP.
  - STOP: o_tx=1 for STOP_BITS bit periods.
- End of the last stop bit: o_done pulses. Then:
  - if the holding register is full, load it into the shift register and go to START;
  - otherwise go to IDLE.
- Accept rules:
  - In IDLE, an accepted word goes straight to the shift register.
  - While busy, an accepted word goes to the holding register, which is then full.
  - o_ready = !hold_full.
- Simultaneous events:
  - Transfer accepted in the last cycle of the last stop bit with hold empty: the word goes straight to the shift register and the FSM goes to START. No idle cycle.
  - Hold full at that same edge: the hold contents move to the shift register and o_ready rises at the same edge.
- i_data is sampled only on the transfer cycle. Later changes have no effect.
- Clock counter width is $clog2(CLK_PER_BIT). Bit index width is $clog2(DATA_BITS+1). Neither wraps except by explicit reset to 0 at each bit or word boundary.
- Illegal parameter values are caught by an elaboration-time check that fails the build.

## Timing
- Transfer accepted at edge k from IDLE: o_tx=0 and o_busy=1 from edge k (registered), for exactly CLK_PER_BIT cycles.
- Every bit lasts exactly CLK_PER_BIT cycles.
- Frame length = CLK_PER_BIT × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- o_done is high for the single cycle after the final stop-bit cycle. In that cycle o_busy=0 (IDLE) or o_tx=0 (next START).
- Back-to-back throughput: one frame per frame length, with no gap.
- o_ready changes only on clock edges. It never depends combinationally on i_valid.

## Structure
- Package uart_pkg holds:
  - state encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, PAR=3'd3, STOP=3'd4;
  - parity constants: PAR_NONE, PAR_ODD, PAR_EVEN.
- One sub-module, uart_baud_cnt: a counter parametrised by CLK_PER_BIT, with clear input and a bit_end pulse output. It will be reused by the planned matching receiver.
- Everything else stays in uart_tx_frm: FSM, shift register, holding register, parity.

## Test plan
- Reset value check: CLK_PER_BIT=4, 8N1. Assert rst_n low → o_tx=1, o_ready=1, o_busy=0, o_state=0.
- Single 8N1 frame: send 0xA5 → o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, frame 40 cycles. o_done pulses once at cycle 40.
- Parity, data width and stop bits: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 7'h13 → bits 0,1,1,0,0,1,0,0,1,1,1. Parity bit=1, frame 44 cycles.
- Odd parity: 8O1, send 0x00 → parity bit=1. Send 0xFF → parity bit=1.
- Back-to-back: 0x55 accepted, then 0x0F accepted on the next cycle → o_ready low until the first o_done. Second start bit begins at cycle 40 with no idle cycle. A third word offered while hold is full is not accepted.
- Reset mid-DATA: pulse rst_n low at cycle 15 with hold full → o_tx=1 immediately, no o_done. After release, o_ready=1 and the line stays idle.
